// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: two-requester arbiter for a shared mode-0 SPI link.
// Each granted frame shifts one word out on MOSI and captures one from MISO.
module spi_xfer_sched #(
    parameter int CLK_DIV = 50,
    parameter int WIDTH   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             req1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             sclk,
    output logic             mosi,
    output logic             cs_n,
    input  logic             miso
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int BW = $clog2(2 * WIDTH);
    localparam logic [PW-1:0] PS_LAST  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           state_q;
    logic [PW-1:0]    ps_q;
    logic [BW-1:0]    bit_q;
    logic [WIDTH-1:0] tx_q;
    logic [WIDTH-1:0] rx_q;
    logic [WIDTH-1:0] rdata_q;
    logic             owner_q;
    logic             last_q;
    logic             gnt0_q, gnt1_q, done0_q, done1_q;
    logic             busy_q, sclk_q, mosi_q, cs_n_q;

    logic             tick_d;
    logic             pick0_d;
    logic             pick1_d;
    logic [PW-1:0]    ps_d;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        tick_d  = (ps_q == PS_LAST);
        pick1_d = req1 & (~req0 | ~last_q);
        pick0_d = req0 & ~pick1_d;
        ps_d    = tick_d ? '0 : ps_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ps_q    <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    ps_q <= '0;
                    if (pick0_d | pick1_d) begin
                        gnt0_q  <= pick0_d;
                        gnt1_q  <= pick1_d;
                        tx_q    <= pick1_d ? wdata1 : wdata0;
                        mosi_q  <= pick1_d ? wdata1[WIDTH-1] : wdata0[WIDTH-1];
                        owner_q <= pick1_d;
                        last_q  <= pick1_d;
                        busy_q  <= 1'b1;
                        cs_n_q  <= 1'b0;
                        bit_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    ps_q <= ps_d;
                    if (tick_d) begin
                        bit_q <= bit_q + 1'b1;
                        if (!bit_q[0]) begin
                            sclk_q <= 1'b1;
                            rx_q   <= {rx_q[WIDTH-2:0], miso};
                        end else begin
                            sclk_q <= 1'b0;
                            tx_q   <= tx_q << 1;
                            mosi_q <= tx_q[WIDTH-2];
                            if (bit_q == BIT_LAST) begin
                                mosi_q  <= 1'b0;
                                cs_n_q  <= 1'b1;
                                state_q <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    ps_q <= ps_d;
                    if (tick_d) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ps_q    <= '0;
                    rdata_q <= rx_q;
                    done0_q <= ~owner_q;
                    done1_q <= owner_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign sclk  = sclk_q;
    assign mosi  = mosi_q;
    assign cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// tb_spi_xfer_sched: randomized transaction-level scoreboard bench.
// The bench plays the SPI slave and predicts grant order from the fairness rule.
module tb_spi_xfer_sched;

    localparam int D     = 2;
    localparam int W     = 16;
    localparam int FRAME = (2 * W + 1) * D + 1;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic [W-1:0] wdata0 = '0;
    logic [W-1:0] wdata1 = '0;
    logic         miso = 1'b0;
    logic         gnt0, gnt1, done0, done1, busy, sclk, mosi, cs_n;
    logic [W-1:0] rdata;

    spi_xfer_sched #(.CLK_DIV(D), .WIDTH(W)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .wdata0(wdata0),
        .req1(req1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1),
        .rdata(rdata), .busy(busy),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .miso(miso)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit           owner;
        logic [W-1:0] wd;
        logic [W-1:0] sw;
    } exp_t;

    exp_t eq[$];
    exp_t cur;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int gnt_cyc = 0, rise_cyc = 0, rise_cnt = 0, idx = 0;
    int gnt_cnt = 0, done_cnt = 0, sclk_edges = 0;
    bit in_frame = 0, have_prev = 0, last_m = 1;
    logic [W-1:0] cap = '0;
    logic [W-1:0] rdata_m = '0;
    logic [W-1:0] prev_rdata = '0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor and SPI slave model
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (RST) begin
                in_frame = 0;
                rise_cnt = 0;
                have_prev = 0;
                rdata_m = '0;
                idx = 0;
                miso = 1'b0;
            end else begin
                if (gnt0 | gnt1) begin
                    chk("gnt_exclusive", 32'(gnt0 & gnt1), 0);
                    if (eq.size() == 0) begin
                        chk("unexpected_gnt", {gnt0, gnt1}, 0);
                    end else begin
                        cur = eq.pop_front();
                        chk("gnt_owner", 32'(gnt1), 32'(cur.owner));
                    end
                    chk("gnt_busy_edge", {prev_busy, busy}, 2'b01);
                    gnt_cyc = cyc;
                    in_frame = 1;
                    rise_cnt = 0;
                    gnt_cnt++;
                end
                if (prev_cs && !cs_n) begin
                    if (have_prev)
                        chk("cs_gap_ge_div_plus_2", 32'(cyc - rise_cyc >= D + 2), 1);
                    idx = 0;
                    cap = '0;
                    miso = cur.sw[W-1];
                end
                if (!prev_sclk && sclk) begin
                    chk("sclk_while_cs_high", 32'(cs_n), 0);
                    cap = {cap[W-2:0], mosi};
                    if (rise_cnt == 0)
                        chk("first_sclk_rise", cyc - gnt_cyc, D);
                    rise_cnt++;
                end
                if (prev_sclk && !sclk) begin
                    idx++;
                    if (idx < W) miso = cur.sw[W-1-idx];
                end
                if (!prev_cs && cs_n) begin
                    chk("sclk_pulses", rise_cnt, W);
                    rise_cyc = cyc;
                    have_prev = 1;
                end
                if (done0 | done1) begin
                    chk("done_exclusive", 32'(done0 & done1), 0);
                    if (!in_frame) begin
                        chk("unexpected_done", {done0, done1}, 0);
                    end else begin
                        chk("done_owner", 32'(done1), 32'(cur.owner));
                        chk("rdata", rdata, cur.sw);
                        chk("mosi_word", cap, cur.wd);
                        chk("done_latency", cyc - gnt_cyc, FRAME);
                        chk("done_busy_edge", {prev_busy, busy}, 2'b10);
                        chk("rdata_hold", prev_rdata, rdata_m);
                        rdata_m = cur.sw;
                        in_frame = 0;
                    end
                    done_cnt++;
                end
                if (sclk != prev_sclk) sclk_edges++;
            end
            prev_cs = cs_n;
            prev_sclk = sclk;
            prev_busy = busy;
            prev_rdata = rdata;
        end
    end

    task automatic push(input bit o, input logic [W-1:0] wd, input logic [W-1:0] sw);
        exp_t e;
        e.owner = o;
        e.wd = wd;
        e.sw = sw;
        eq.push_back(e);
    endtask

    task automatic wait_gnt(input bit id);
        int n;
        for (n = 0; n < 400; n++) begin
            @(negedge CLK);
            if (id ? gnt1 : gnt0) break;
        end
        chk(id ? "gnt1_timeout" : "gnt0_timeout", 32'(n < 400), 1);
    endtask

    task automatic wait_done(input bit id);
        int n;
        for (n = 0; n < 400; n++) begin
            @(negedge CLK);
            if (id ? done1 : done0) break;
        end
        chk(id ? "done1_timeout" : "done0_timeout", 32'(n < 400), 1);
    endtask

    task automatic drop(input bit id, input bit chg);
        if (id) begin
            req1 = 1'b0;
            if (chg) wdata1 = W'($urandom);
        end else begin
            req0 = 1'b0;
            if (chg) wdata0 = W'($urandom);
        end
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        repeat (n) @(negedge CLK);
        chk("rst_cs_n", 32'(cs_n), 1);
        chk("rst_sclk", 32'(sclk), 0);
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_pulses", {gnt0, gnt1, done0, done1}, 0);
        eq.delete();
        last_m = 1;
        RST = 1'b0;
    endtask

    // Grant order: a lone requester wins; on a tie the one not granted last wins.
    task automatic round(input bit r0, input bit r1, input bit chg,
                         input logic [W-1:0] wd0, input logic [W-1:0] wd1,
                         input logic [W-1:0] swa, input logic [W-1:0] swb);
        bit first, second;
        @(negedge CLK);
        if (r0 && r1) begin
            first = !last_m;
            second = !first;
        end else begin
            first = r1;
            second = first;
        end
        push(first, first ? wd1 : wd0, swa);
        if (r0 && r1) push(second, second ? wd1 : wd0, swb);
        last_m = second;
        wdata0 = wd0;
        wdata1 = wd1;
        req0 = r0;
        req1 = r1;
        wait_gnt(first);
        drop(first, chg);
        if (r0 && r1) begin
            wait_gnt(second);
            drop(second, chg);
        end
        wait_done(second);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int g, e, n, m;
        logic [W-1:0] wa, wb;
        do_reset(3);

        round(1, 0, 1, 16'hA5C3, 16'h0000, W'($urandom), '0);
        round(0, 1, 1, 16'h0000, 16'h1234, 16'h1234, '0);

        do_reset(2);
        wa = W'($urandom);
        wb = W'($urandom);
        push(0, wa, W'($urandom));
        push(1, wb, W'($urandom));
        push(0, wa, W'($urandom));
        push(1, wb, W'($urandom));
        last_m = 1;
        wdata0 = wa;
        wdata1 = wb;
        req0 = 1'b1;
        req1 = 1'b1;
        wait_gnt(0);
        wait_gnt(1);
        wait_gnt(0);
        wait_gnt(1);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_done(1);

        @(negedge CLK);
        wa = W'($urandom);
        push(0, wa, W'($urandom));
        last_m = 0;
        wdata0 = wa;
        req0 = 1'b1;
        wait_gnt(0);
        req0 = 1'b0;
        wdata0 = ~wa;
        repeat (10) @(negedge CLK);
        req1 = 1'b1;
        @(negedge CLK);
        req1 = 1'b0;
        g = gnt_cnt;
        wait_done(0);
        repeat (100) @(negedge CLK);
        chk("no_gnt_after_dropped_req", gnt_cnt, g);

        @(negedge CLK);
        wb = W'($urandom);
        push(1, wb, W'($urandom));
        last_m = 1;
        wdata1 = wb;
        req1 = 1'b1;
        wait_gnt(1);
        req1 = 1'b0;
        for (n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (rise_cnt >= 7) break;
        end
        chk("reach_bit7", 32'(n < 200), 1);
        do_reset(1);
        e = done_cnt;
        repeat (150) @(negedge CLK);
        chk("no_done_after_reset", done_cnt, e);
        round(0, 1, 0, '0, W'($urandom), W'($urandom), '0);

        for (int i = 0; i < 25; i++) begin
            m = $urandom_range(1, 3);
            round(m[0], m[1], 1'($urandom), W'($urandom), W'($urandom),
                  W'($urandom), W'($urandom));
        end

        g = gnt_cnt;
        e = sclk_edges;
        repeat (1000) @(negedge CLK);
        chk("idle_gnt_count", gnt_cnt, g);
        chk("idle_sclk_edges", sclk_edges, e);
        chk("idle_cs_n", 32'(cs_n), 1);
        chk("idle_sclk", 32'(sclk), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_pulses", {gnt0, gnt1, done0, done1}, 0);
        chk("scoreboard_empty", eq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
